// File: rtl/preemph_framer.sv
// preemph_framer
//   First-order pre-emphasis (y = x - ALPHA*x_prev, Q15, saturating) feeding a
//   circular frame buffer. Every HOP new samples (after an initial fill of N)
//   the last N samples are replayed oldest-first as an N-cycle valid burst.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   sample_in/_valid    INT16 Q15 input stream, no backpressure
//   sample_out/_valid   pre-emphasized frame sample stream
//   frame_start/_end    first / last sample of a burst
//   overrun             sticky: a frame trigger arrived mid-burst and was dropped
module preemph_framer #(
  parameter int                 N     = 256,
  parameter int                 HOP   = 128,
  parameter logic signed [15:0] ALPHA = 16'sd31785
) (
  input  logic               clk,
  input  logic               rst,
  input  logic signed [15:0] sample_in,
  input  logic               sample_valid,
  output logic signed [15:0] sample_out,
  output logic               sample_out_valid,
  output logic               frame_start,
  output logic               frame_end,
  output logic               overrun
);

  localparam int PW = $clog2(N);
  localparam int HW = PW + 1;
  localparam logic [PW-1:0] K_LAST = PW'(N - 1);
  localparam logic [HW-1:0] HOP_L  = HW'(HOP);

  typedef enum logic [1:0] {S_FILL, S_IDLE, S_EMIT} state_t;

  state_t             state_q, state_d;
  logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]      fill_q, fill_d;
  logic [HW-1:0]      hop_q, hop_d, hop_inc;
  logic [PW-1:0]      base_q, base_d;
  logic [PW-1:0]      k_q, k_d;
  logic [PW-1:0]      rd_addr;
  logic signed [15:0] x_prev_q, x_prev_d;
  logic signed [15:0] out_q, out_d;
  logic               ovr_q, ovr_d;
  logic               trig, last;

  logic signed [15:0] mem_q [N];

  // Pre-emphasis datapath
  logic signed [31:0] prod;
  logic signed [16:0] psh;
  logic [16:0]        d_full;
  logic signed [15:0] d_sat;

  always_comb begin
    prod   = ALPHA * x_prev_q;
    psh    = 17'(prod >>> 15);           // floor(ALPHA*x_prev / 2^15), fits 16 bits
    d_full = {sample_in[15], sample_in} - psh;
    // 17-bit result overflowed 16 bits when the top two bits differ
    if (d_full[16] != d_full[15]) d_sat = d_full[16] ? -16'sd32768 : 16'sd32767;
    else                          d_sat = d_full[15:0];
  end

  // Next-state / control
  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    fill_d   = fill_q;
    hop_d    = hop_q;
    base_d   = base_q;
    k_d      = k_q;
    x_prev_d = x_prev_q;
    out_d    = out_q;
    ovr_d    = ovr_q;
    trig     = 1'b0;
    hop_inc  = hop_q + 1'b1;
    last     = (state_q == S_EMIT) && (k_q == K_LAST);

    if (sample_valid) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
      x_prev_d = sample_in;
      if (state_q == S_FILL) begin
        fill_d = fill_q + 1'b1;
        hop_d  = '0;
        trig   = (fill_q == K_LAST);
      end else if (hop_inc == HOP_L) begin
        hop_d = '0;
        trig  = 1'b1;
      end else begin
        hop_d = hop_inc;
      end
    end

    case (state_q)
      S_FILL, S_IDLE: begin
        if (trig) begin
          state_d = S_EMIT;
          base_d  = wr_ptr_d;            // oldest sample once this write lands
          k_d     = '0;
        end
      end
      S_EMIT: begin
        if (last) begin
          // A trigger coinciding with the final read chains straight into the next burst
          if (trig) begin
            base_d = wr_ptr_d;
            k_d    = '0;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          k_d = k_q + 1'b1;
          if (trig) ovr_d = 1'b1;
        end
      end
      default: state_d = S_FILL;
    endcase

    // Output register loads the sample it will present. The address is never the
    // one being written on this edge (the write pointer trails the read pointer),
    // so reading the pre-edge array gives read-before-write semantics.
    rd_addr = base_d + k_d;
    if (state_d == S_EMIT) out_d = mem_q[rd_addr];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_FILL;
      wr_ptr_q <= '0;
      fill_q   <= '0;
      hop_q    <= '0;
      base_q   <= '0;
      k_q      <= '0;
      x_prev_q <= '0;
      out_q    <= '0;
      ovr_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      fill_q   <= fill_d;
      hop_q    <= hop_d;
      base_q   <= base_d;
      k_q      <= k_d;
      x_prev_q <= x_prev_d;
      out_q    <= out_d;
      ovr_q    <= ovr_d;
    end
  end

  // Frame buffer: no reset, contents are don't-care until written
  always_ff @(posedge clk) begin
    if (sample_valid) mem_q[wr_ptr_q] <= d_sat;
  end

  assign sample_out       = out_q;
  assign sample_out_valid = (state_q == S_EMIT);
  assign frame_start      = (state_q == S_EMIT) && (k_q == '0);
  assign frame_end        = last;
  assign overrun          = ovr_q;

endmodule

// File: tb/tb_preemph_framer.sv
// Testbench for preemph_framer: randomized and directed streams checked against
// a queue-based model (sample history + pending-output queue).
module tb_preemph_framer;

  localparam int N   = 256;
  localparam int HOP = 128;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic signed [15:0] sample_in = '0;
  logic               sample_valid = 1'b0;
  logic signed [15:0] sample_out;
  logic               sample_out_valid, frame_start, frame_end, overrun;

  preemph_framer #(.N(N), .HOP(HOP), .ALPHA(16'sd31785)) dut (
    .clk(clk), .rst(rst),
    .sample_in(sample_in), .sample_valid(sample_valid),
    .sample_out(sample_out), .sample_out_valid(sample_out_valid),
    .frame_start(frame_start), .frame_end(frame_end), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct { int val; int k; } item_t;
  int    xp, nsamp, last_val;
  int    hist[$];
  item_t expq[$];
  item_t cur;
  bit    m_v, m_ovr;

  function automatic int pe(input int x, input int p);
    int d;
    d = x - ((31785 * p) >>> 15);      // floor division by 2^15
    if (d > 32767)  d = 32767;
    if (d < -32768) d = -32768;
    return d;
  endfunction

  task automatic model_reset();
    xp = 0; nsamp = 0; last_val = 0; m_v = 0; m_ovr = 0;
    hist.delete(); expq.delete();
  endtask

  task automatic model_edge(input bit v, input int x);
    if (v) begin
      hist.push_back(pe(x, xp));
      xp = x;
      if (hist.size() > N) void'(hist.pop_front());
      nsamp++;
      if (nsamp == N || (nsamp > N && (nsamp - N) % HOP == 0)) begin
        if (expq.size() > 0) m_ovr = 1;
        else for (int i = 0; i < N; i++) expq.push_back('{val: hist[i], k: i});
      end
    end
    if (expq.size() > 0) begin
      cur = expq.pop_front();
      m_v = 1;
      last_val = cur.val;
    end else begin
      m_v = 0;
    end
  endtask

  task automatic cmp();
    chk("valid", sample_out_valid, m_v);
    chk("overrun", overrun, m_ovr);
    if (m_v) begin
      chk("data", sample_out, cur.val);
      chk("start", frame_start, cur.k == 0);
      chk("end", frame_end, cur.k == N - 1);
    end else begin
      chk("hold", sample_out, last_val);
      chk("start_idle", frame_start, 0);
      chk("end_idle", frame_end, 0);
    end
  endtask

  task automatic step(input bit v, input logic signed [15:0] x);
    sample_valid = v;
    sample_in    = x;
    @(posedge clk);
    model_edge(v, int'(x));
    #1 cmp();
  endtask

  // Asserts reset away from any clock edge and checks outputs clear immediately
  task automatic do_reset();
    sample_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("rst_valid", sample_out_valid, 0);
    chk("rst_start", frame_start, 0);
    chk("rst_end", frame_end, 0);
    chk("rst_ovr", overrun, 0);
    chk("rst_out", sample_out, 0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  function automatic logic signed [15:0] rnd16();
    logic [31:0] r;
    r = $urandom;
    return r[15:0];
  endfunction

  initial begin
    logic signed [15:0] dir_x [5];
    int                 dir_y [5];
    bit                 found;

    dir_x[0] = 16'sd1000;  dir_x[1] = 16'sd1000;  dir_x[2] = 16'sd32767;
    dir_x[3] = -16'sd32768; dir_x[4] = 16'sd32767;
    dir_y[0] = 1000; dir_y[1] = 30; dir_y[2] = 31797; dir_y[3] = -32768; dir_y[4] = 32767;

    // Scenario 1: ramp, sample_valid every 4th cycle -> fill, then overlapped frames
    #2;
    do_reset();
    for (int i = 0; i < 520; i++) begin
      step(0, '0); step(0, '0); step(0, '0);
      step(1, 16'(i));
    end
    for (int i = 0; i < N + 8; i++) step(0, '0);

    // Scenario 2: directed first samples (reset carry, saturation both ways), continuous
    do_reset();
    for (int i = 0; i < 5; i++) step(1, dir_x[i]);
    for (int i = 5; i < N; i++) step(1, rnd16());
    for (int i = 0; i < 5; i++) begin
      if (i > 0) step(0, '0);
      chk($sformatf("y%0d", i), sample_out, dir_y[i]);
    end

    // Scenario 3: continuous writes force overrun; reset in a later burst at k=100
    found = 0;
    for (int i = 0; i < 3000 && !found; i++) begin
      step(1, rnd16());
      if (m_ovr && m_v && cur.k == 100 && nsamp > 600) found = 1;
    end
    chk("reached_k100", found, 1);
    chk("ovr_sticky", overrun, 1);
    #2;
    do_reset();

    // Scenario 4: refill after reset, random valid pattern
    for (int i = 0; i < 1400; i++) step($urandom_range(0, 1), rnd16());
    for (int i = 0; i < N + 8; i++) step(0, '0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
